// File: rtl/fsm_rx.sv
// fsm_rx - UART receive controller.
//
// Oversamples the serial line with the BCLK tick (OVERSAMPLE ticks per bit),
// qualifies the start bit at its mid-point, samples each following bit once
// per bit period and reassembles an 8-bit LSB-first frame.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : start, 8 data, even parity, stop; parity_err is live.
//   undefined : start, 8 data, stop; parity_err is tied 0.
//
// Ports:
//   clk        system clock, rising edge
//   arst_n     asynchronous active-low reset
//   rx_en      receive enable; low forces IDLE and drops any partial frame
//   BCLK       one-clk tick at OVERSAMPLE x baud
//   rx         serial line (idle high), asynchronous to clk
//   data       last received byte, updated only when done rises
//   done       one-cycle pulse, data/flags valid
//   busy       high while a frame is in progress
//   frame_err  stop bit sampled low; held until next done
//   parity_err parity mismatch; held until next done
module fsm_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       rx_en,
    input  logic       BCLK,
    input  logic       rx,
    output logic [7:0] data,
    output logic       done,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_DONE
    } state_t;
`endif

    state_t          state, state_n;
    logic [TW-1:0]   tick, tick_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      shift, shift_n;
    logic            rx_meta, rx_s;
    logic            ld_out;
    logic            busy_n;

    // Two-flop synchronizer; resets to the idle-line level so no false start
    // is seen coming out of reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic pmis, pmis_n;
`endif

    always_comb begin
        state_n = state;
        tick_n  = tick;
        idx_n   = idx;
        shift_n = shift;
        ld_out  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pmis_n  = pmis;
`endif
        if (!rx_en) begin
            state_n = S_IDLE;
            tick_n  = '0;
            idx_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tick_n = '0;
                    idx_n  = '0;
                    if (!rx_s) state_n = S_START;
                end
                S_START: if (BCLK) begin
                    // Mid-point of the start bit: a high line means a glitch.
                    if (tick == TICK_HALF) begin
                        tick_n  = '0;
                        state_n = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
                S_DATA: if (BCLK) begin
                    if (tick == TICK_LAST) begin
                        shift_n = {rx_s, shift[7:1]};
                        tick_n  = '0;
                        if (idx == 3'd7) begin
                            idx_n = '0;
`ifdef UART_RX_PARITY_EN
                            state_n = S_PARITY;
`else
                            state_n = S_STOP;
`endif
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (BCLK) begin
                    if (tick == TICK_LAST) begin
                        // Even parity: line bit must equal XOR of the data.
                        pmis_n  = rx_s ^ (^shift);
                        tick_n  = '0;
                        state_n = S_STOP;
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
`endif
                S_STOP: if (BCLK) begin
                    // A bad stop bit is only flagged; the byte is still delivered.
                    if (tick == TICK_LAST) begin
                        ld_out  = 1'b1;
                        tick_n  = '0;
                        state_n = S_DONE;
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_n = 1'b0;
        case (state_n)
            S_START, S_DATA, S_STOP: busy_n = 1'b1;
`ifdef UART_RX_PARITY_EN
            S_PARITY:                busy_n = 1'b1;
`endif
            default:                 busy_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_IDLE;
            tick  <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            tick  <= tick_n;
            idx   <= idx_n;
            shift <= shift_n;
        end
    end

    // Outputs registered from next-state so they line up with the state
    // without any input-to-output combinational path.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data      <= 8'h00;
            done      <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            done <= (state_n == S_DONE);
            busy <= busy_n;
            if (ld_out) begin
                data      <= shift;
                frame_err <= ~rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pmis       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            pmis <= pmis_n;
            if (ld_out) parity_err <= pmis;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_rx.sv
// tb_fsm_rx - self-checking bench for fsm_rx.
// Drives whole UART frames on rx at a fixed bit period and compares the
// received byte/flags against the frame the bench built itself.
module tb_fsm_rx;

    localparam int OS   = 16;
    localparam int BDIV = 4;
    localparam int BIT  = OS * BDIV;

    logic       clk, arst_n, rx_en, BCLK, rx;
    logic [7:0] data;
    logic       done, busy, frame_err, parity_err;

    fsm_rx #(.OVERSAMPLE(OS)) dut (
        .clk(clk), .arst_n(arst_n), .rx_en(rx_en), .BCLK(BCLK), .rx(rx),
        .data(data), .done(done), .busy(busy),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        BCLK = 1'b0;
        forever begin
            repeat (BDIV - 1) @(negedge clk);
            BCLK = 1'b1;
            @(negedge clk);
            BCLK = 1'b0;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Monitor: counts done pulses, over-long pulses and output changes that
    // happen without done.
    int   done_cnt = 0, dbl_cnt = 0, bad_chg = 0;
    logic prev_done = 1'b0;
    logic [9:0] prev_out = '0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!arst_n) begin
                prev_done = 1'b0;
                prev_out  = {data, frame_err, parity_err};
            end else begin
                if (done) done_cnt++;
                if (done && prev_done) dbl_cnt++;
                if ({data, frame_err, parity_err} !== prev_out && !done) bad_chg++;
                prev_done = done;
                prev_out  = {data, frame_err, parity_err};
            end
        end
    end

    // Reference: what the outputs must hold after each completed frame.
    int         exp_done = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_ferr = 1'b0, exp_perr = 1'b0;

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b);
`endif
        if (stop_b) drive_bit(1'b1);
        else begin
            // Low stop bit released after its sample point so the line
            // does not look like a new start bit for long.
            rx = 1'b0;
            repeat (40) @(negedge clk);
            rx = 1'b1;
            repeat (BIT - 40) @(negedge clk);
        end
    endtask

    task automatic rx_frame(input string tag, input logic [7:0] d, input logic stop_b,
                            input logic par_b, input int gap);
        send_frame(d, stop_b, par_b);
        idle(gap);
        exp_done++;
        exp_data = d;
        exp_ferr = ~stop_b;
`ifdef UART_RX_PARITY_EN
        exp_perr = par_b ^ (^d);
`else
        exp_perr = 1'b0;
`endif
        chk({tag, "_done"}, done_cnt, exp_done);
        chk({tag, "_data"}, data, exp_data);
        chk({tag, "_ferr"}, frame_err, exp_ferr);
        chk({tag, "_perr"}, parity_err, exp_perr);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic       sb, pb;
        int         gap;
        arst_n = 1'b0;
        rx     = 1'b1;
        rx_en  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        arst_n = 1'b1;
        idle(40);

        rx_frame("nominal", 8'hA5, 1'b1, ^8'hA5, 20);
        rx_frame("framing", 8'h3C, 1'b0, ^8'h3C, 20);

        // Reset in the middle of the data bits of a new frame.
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        chk("midrst_busy_before", busy, 1'b1);
        arst_n = 1'b0;
        #1;
        chk("midrst_data", data, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ferr", frame_err, 1'b0);
        chk("midrst_done", done, 1'b0);
        exp_data = 8'h00; exp_ferr = 1'b0; exp_perr = 1'b0;
        repeat (4) @(negedge clk);
        arst_n = 1'b1;
        idle(200);
        chk("postrst_busy", busy, 1'b0);
        chk("postrst_done", done_cnt, exp_done);

        rx_frame("good01", 8'h01, 1'b1, ^8'h01, 20);

        // Glitch: start latency, then a short low pulse rejected at mid-bit.
        rx = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("start_lat_early", busy, 1'b0);
        @(posedge clk); #1;
        chk("start_lat_busy", busy, 1'b1);
        @(negedge clk);
        repeat (3 * BDIV - 3) @(negedge clk);
        idle(80);
        chk("glitch_busy", busy, 1'b0);
        chk("glitch_done", done_cnt, exp_done);
        chk("glitch_data", data, exp_data);

        // Abort during bit 4 of 8'hFF.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        rx_en = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 1'b0);
        @(negedge clk);
        repeat (BIT * 5) @(negedge clk);
        rx_en = 1'b1;
        idle(20);
        chk("abort_done", done_cnt, exp_done);
        chk("abort_data", data, exp_data);
        rx_frame("after_abort", 8'h55, 1'b1, ^8'h55, 20);

`ifdef UART_RX_PARITY_EN
        rx_frame("par_bad", 8'h07, 1'b1, 1'b0, 20);
        rx_frame("par_good", 8'h07, 1'b1, 1'b1, 20);
`endif
        rx_frame("b2b_a", 8'hC3, 1'b1, ^8'hC3, 0);
        rx_frame("b2b_b", 8'h5A, 1'b1, ^8'h5A, 20);

        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            pb  = (^d) ^ ($urandom_range(0, 3) == 0);
            gap = sb ? int'($urandom_range(0, 20)) : int'($urandom_range(16, 30));
            rx_frame($sformatf("rand%0d", k), d, sb, pb, gap);
        end

        idle(50);
        chk("done_width", dbl_cnt, 0);
        chk("out_stable", bad_chg, 0);
        chk("done_total", done_cnt, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
